// File: rtl/fb_frame_ctrl.sv
// Frame-aligned capture sequencer: passes capture writes to the frame buffer only for
// whole frames, with continuous, single-shot and stop/freeze operation.
module fb_frame_ctrl #(
    parameter int c_img_pxls     = 4800,
    parameter int c_nb_img_pxls  = 13,
    parameter int c_skip_frames  = 2,
    parameter int c_nb_frame_cnt = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_done,
    input  logic                      cam_vsync,
    input  logic                      mode_cont,
    input  logic                      snap_req,
    input  logic                      stop_req,
    input  logic                      cap_we,
    input  logic [c_nb_img_pxls-1:0]  cap_addr,
    output logic                      fb_we,
    output logic                      frame_done,
    output logic [c_nb_frame_cnt-1:0] frame_cnt,
    output logic                      frozen,
    output logic                      addr_err,
    output logic [2:0]                state_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SKIP    = 3'd1,
        S_ARM     = 3'd2,
        S_CAPTURE = 3'd3,
        S_HOLD    = 3'd4
    } state_t;

    localparam int c_nb_skip = (c_skip_frames > 0) ? $clog2(c_skip_frames + 1) : 1;
    localparam logic [c_nb_skip-1:0]   c_skip_last = c_nb_skip'(c_skip_frames - 1);
    localparam logic [c_nb_img_pxls:0] c_addr_lim  = (c_nb_img_pxls + 1)'(c_img_pxls);

    state_t                    state_q;
    logic [c_nb_skip-1:0]      skip_cnt_q;
    logic [c_nb_frame_cnt-1:0] frame_cnt_q;
    logic [c_nb_frame_cnt-1:0] frame_cnt_d;
    logic                      frame_done_q;
    logic                      addr_err_q;
    logic                      stop_pending_q;
    logic                      vs_meta_q;
    logic                      vs_sync_q;
    logic                      vs_prev_q;
    logic                      vs_fall_s;
    logic                      vs_rise_s;
    logic                      in_range_s;
    logic                      hold_to_arm_s;

    // vsync low marks the active frame: falling edge starts it, rising edge ends it
    assign vs_fall_s     = vs_prev_q & ~vs_sync_q;
    assign vs_rise_s     = ~vs_prev_q & vs_sync_q;
    assign in_range_s    = {1'b0, cap_addr} < c_addr_lim;
    assign frame_cnt_d   = frame_cnt_q + c_nb_frame_cnt'(1);
    assign hold_to_arm_s = snap_req | (mode_cont & ~stop_pending_q & ~stop_req);

    // Two-flop synchronizer plus the delayed copy used for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_meta_q <= 1'b0;
            vs_sync_q <= 1'b0;
            vs_prev_q <= 1'b0;
        end else begin
            vs_meta_q <= cam_vsync;
            vs_sync_q <= vs_meta_q;
            vs_prev_q <= vs_sync_q;
        end
    end

    // Sequencer state, skip/frame counters, stop request latch and error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            skip_cnt_q     <= '0;
            frame_cnt_q    <= '0;
            frame_done_q   <= 1'b0;
            addr_err_q     <= 1'b0;
            stop_pending_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if ((state_q == S_CAPTURE) && cap_we && !in_range_s) begin
                addr_err_q <= 1'b1;
            end
            // snap only clears the latch in HOLD; elsewhere stop wins and snap is dropped
            if ((state_q == S_HOLD) && snap_req) begin
                stop_pending_q <= 1'b0;
            end else if (stop_req && (state_q != S_IDLE)) begin
                stop_pending_q <= 1'b1;
            end
            if (!cfg_done) begin
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        skip_cnt_q <= '0;
                        state_q    <= (c_skip_frames == 0) ? S_ARM : S_SKIP;
                    end
                    S_SKIP: begin
                        if (vs_rise_s) begin
                            if (skip_cnt_q == c_skip_last) begin
                                state_q <= S_ARM;
                            end else begin
                                skip_cnt_q <= skip_cnt_q + c_nb_skip'(1);
                            end
                        end
                    end
                    S_ARM: begin
                        if (vs_fall_s) begin
                            state_q <= S_CAPTURE;
                        end
                    end
                    S_CAPTURE: begin
                        if (vs_rise_s) begin
                            frame_done_q <= 1'b1;
                            frame_cnt_q  <= frame_cnt_d;
                            if (stop_pending_q || stop_req || !mode_cont) begin
                                state_q <= S_HOLD;
                            end else begin
                                state_q <= S_ARM;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (hold_to_arm_s) begin
                            state_q <= S_ARM;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Write gate is zero-latency so the address stays aligned with its strobe
    assign fb_we      = (state_q == S_CAPTURE) & cap_we & in_range_s;
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;
    assign frozen     = (state_q == S_HOLD);
    assign addr_err   = addr_err_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_fb_frame_ctrl.sv
// Directed bench for fb_frame_ctrl: per-frame write/frame_done expectations go through a
// scoreboard queue and are compared when the frame has ended.
module tb_fb_frame_ctrl;

    logic        clk;
    logic        rst;
    logic        cfg_done;
    logic        cam_vsync;
    logic        mode_cont;
    logic        snap_req;
    logic        stop_req;
    logic        cap_we;
    logic [12:0] cap_addr;
    logic        fb_we;
    logic        frame_done;
    logic [7:0]  frame_cnt;
    logic        frozen;
    logic        addr_err;
    logic [2:0]  state_o;

    typedef struct {
        int wr;
        int done;
    } exp_t;

    exp_t sb[$];
    int   n_tests;
    int   n_fail;
    int   wr_total;
    int   done_total;
    int   exp_cnt;

    fb_frame_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_done   (cfg_done),
        .cam_vsync  (cam_vsync),
        .mode_cont  (mode_cont),
        .snap_req   (snap_req),
        .stop_req   (stop_req),
        .cap_we     (cap_we),
        .cap_addr   (cap_addr),
        .fb_we      (fb_we),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt),
        .frozen     (frozen),
        .addr_err   (addr_err),
        .state_o    (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count accepted buffer writes and cycles with frame_done high
    always @(negedge clk) begin
        if (fb_we === 1'b1) wr_total <= wr_total + 1;
        if (frame_done === 1'b1) done_total <= done_total + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // ev_kind: 0 none, 1 cfg_done rise, 2 stop, 3 snap, 4 stop+snap, 5 rst pulse, 6 cfg_done drop
    task automatic frame(input int npix, input int exp_wr, input int exp_done,
                         input bit chk_lat, input int ev_at, input int ev_kind);
        exp_t e;
        int   w0;
        int   d0;
        sb.push_back('{exp_wr, exp_done});
        w0 = wr_total;
        d0 = done_total;
        @(posedge clk); #1 cam_vsync = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        if (chk_lat) chk("arm_2clk_after_fall", 32'(state_o), 32'd2);
        @(posedge clk); #1;
        if (chk_lat) chk("capture_3clk_after_fall", 32'(state_o), 32'd3);
        @(posedge clk);
        for (int i = 0; i < npix; i++) begin
            #1;
            cap_we   = 1'b1;
            cap_addr = 13'(i);
            stop_req = ((ev_kind == 2) || (ev_kind == 4)) && (i == ev_at);
            snap_req = ((ev_kind == 3) || (ev_kind == 4)) && (i == ev_at);
            rst      = (ev_kind == 5) && (i == ev_at);
            if ((ev_kind == 1) && (i == ev_at)) cfg_done = 1'b1;
            if ((ev_kind == 6) && (i == ev_at)) cfg_done = 1'b0;
            if ((ev_kind >= 5) && (i == ev_at + 1)) begin
                #1;
                chk("abort_fb_we", 32'(fb_we), 32'd0);
                chk("abort_state", 32'(state_o), 32'd0);
                chk("abort_frame_done", 32'(frame_done), 32'd0);
                if (ev_kind == 5) begin
                    exp_cnt = 0;
                    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
                    chk("rst_addr_err", 32'(addr_err), 32'd0);
                end
            end
            @(posedge clk);
        end
        #1;
        cap_we   = 1'b0;
        stop_req = 1'b0;
        snap_req = 1'b0;
        rst      = 1'b0;
        repeat (3) @(posedge clk);
        #1 cam_vsync = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        exp_cnt = exp_cnt + exp_done;
        e = sb.pop_front();
        chk("frame_writes", 32'(wr_total - w0), 32'(e.wr));
        chk("frame_done_cycles", 32'(done_total - d0), 32'(e.done));
        chk("frame_cnt", 32'(frame_cnt), 32'(exp_cnt % 256));
    endtask

    task automatic pulse_req(input bit stop, input bit snap);
        @(posedge clk); #1;
        stop_req = stop;
        snap_req = snap;
        @(posedge clk); #1;
        stop_req = 1'b0;
        snap_req = 1'b0;
        #1;
    endtask

    initial begin
        n_tests = 0; n_fail = 0; wr_total = 0; done_total = 0; exp_cnt = 0;
        rst = 1'b1; cfg_done = 1'b0; cam_vsync = 1'b1; mode_cont = 1'b1;
        snap_req = 1'b0; stop_req = 1'b0; cap_we = 1'b1; cap_addr = 13'd5;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", 32'(state_o), 32'd0);
        chk("reset_fb_we", 32'(fb_we), 32'd0);
        chk("reset_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("reset_frame_done", 32'(frame_done), 32'd0);
        chk("reset_addr_err", 32'(addr_err), 32'd0);
        chk("reset_frozen", 32'(frozen), 32'd0);
        rst = 1'b0; cap_we = 1'b0;
        repeat (5) @(posedge clk);

        // startup: cfg_done arrives mid-frame, two frames skipped, then continuous capture
        frame(4800, 0, 0, 1'b0, 1000, 1);
        frame(4800, 0, 0, 1'b0, 0, 0);
        frame(4800, 4800, 1, 1'b1, 0, 0);
        frame(4800, 4800, 1, 1'b0, 0, 0);
        chk("startup_state_arm", 32'(state_o), 32'd2);

        // single-shot
        mode_cont = 1'b0;
        frame(8, 8, 1, 1'b0, 0, 0);
        chk("single_hold", 32'(state_o), 32'd4);
        chk("single_frozen", 32'(frozen), 32'd1);
        frame(8, 0, 0, 1'b0, 0, 0);
        chk("hold_still_frozen", 32'(frozen), 32'd1);
        pulse_req(1'b0, 1'b1);
        chk("snap_to_arm", 32'(state_o), 32'd2);
        chk("snap_unfrozen", 32'(frozen), 32'd0);
        frame(8, 8, 1, 1'b0, 0, 0);
        chk("snap_back_hold", 32'(state_o), 32'd4);
        // snap mid-frame: the rest of that frame and its end are ignored
        frame(8, 0, 0, 1'b0, 3, 3);
        frame(8, 8, 1, 1'b1, 0, 0);
        chk("midarm_back_hold", 32'(state_o), 32'd4);

        // stop / snap precedence
        mode_cont = 1'b1;
        frame(4800, 4800, 1, 1'b0, 2000, 2);
        chk("stop_hold", 32'(state_o), 32'd4);
        frame(8, 0, 0, 1'b0, 0, 0);
        chk("stop_stays_hold", 32'(state_o), 32'd4);
        pulse_req(1'b1, 1'b1);
        chk("stop_snap_hold_arm", 32'(state_o), 32'd2);
        frame(8, 8, 1, 1'b0, 0, 0);
        chk("pending_cleared_arm", 32'(state_o), 32'd2);
        frame(8, 8, 1, 1'b0, 0, 4);
        chk("stop_snap_capture_hold", 32'(state_o), 32'd4);
        pulse_req(1'b0, 1'b1);

        // address range
        @(posedge clk); #1 cam_vsync = 1'b0;
        repeat (4) @(posedge clk);
        #1 cap_we = 1'b1; cap_addr = 13'd4800;
        #1 chk("addr_4800_fb_we", 32'(fb_we), 32'd0);
        @(posedge clk); #1 cap_addr = 13'd8191;
        #1 chk("addr_8191_fb_we", 32'(fb_we), 32'd0);
        chk("addr_err_set", 32'(addr_err), 32'd1);
        @(posedge clk); #1 cap_addr = 13'd4799;
        #1 chk("addr_4799_fb_we", 32'(fb_we), 32'd1);
        chk("addr_err_sticky", 32'(addr_err), 32'd1);
        @(posedge clk); #1 cap_we = 1'b0;
        repeat (3) @(posedge clk);
        #1 cam_vsync = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        exp_cnt++;
        chk("addr_frame_cnt", 32'(frame_cnt), 32'(exp_cnt % 256));
        chk("addr_err_still", 32'(addr_err), 32'd1);

        // reset mid-capture, then re-skip
        frame(3200, 3001, 0, 1'b0, 3000, 5);
        frame(2, 0, 0, 1'b0, 0, 0);
        chk("post_rst_arm", 32'(state_o), 32'd2);

        // run up to 255 captured frames
        for (int k = 0; k < 255; k++) frame(2, 2, 1, 1'b0, 0, 0);
        chk("cnt_255", 32'(frame_cnt), 32'd255);

        // cfg_done drop mid-capture keeps frame_cnt
        frame(8, 4, 0, 1'b0, 3, 6);
        chk("cfg_drop_cnt_held", 32'(frame_cnt), 32'd255);
        @(posedge clk); #1 cfg_done = 1'b1;
        frame(2, 0, 0, 1'b0, 0, 0);
        frame(2, 0, 0, 1'b0, 0, 0);
        frame(2, 2, 1, 1'b0, 0, 0);
        chk("cnt_wrap_0", 32'(frame_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fb_frame_ctrl.md
Name: fb_frame_ctrl

Overview:
- Frame-aligned capture sequencer between ov7670_capture and the frame buffer write port.
- Gates the capture write enable so the buffer only ever receives whole frames.
- Supports continuous, single-shot (snapshot) and stop/freeze operation, and counts completed frames for the LED/OLED logic.
- Sits in the oclk domain, downstream of the camera controller's config-done flag.

Parameters:
- c_img_pxls, 4800: pixels per frame; highest valid write address is c_img_pxls-1.
- c_nb_img_pxls, 13: write address width.
- c_skip_frames, 2: frames discarded after configuration completes, before the first capture.
- c_nb_frame_cnt, 8: width of the completed-frame counter.

Ports:
- clk  in  1  system clock (oclk); the only clock.
- rst  in  1  synchronous, active-high reset.
- cfg_done  in  1  camera register configuration finished (level).
- cam_vsync  in  1  raw camera vsync; asynchronous to clk.
- mode_cont  in  1  1 = continuous capture, 0 = single-shot (level).
- snap_req  in  1  one-cycle request to capture one new frame.
- stop_req  in  1  one-cycle request to freeze after the current frame.
- cap_we  in  1  write strobe from the capture block.
- cap_addr  in  c_nb_img_pxls  write address from the capture block.
- fb_we  out  1  gated write enable to the frame buffer.
- frame_done  out  1  one-cycle pulse when a captured frame completes.
- frame_cnt  out  c_nb_frame_cnt  completed captured frames, wraps.
- frozen  out  1  buffer content is stable (HOLD state).
- addr_err  out  1  sticky flag: cap_we seen with cap_addr >= c_img_pxls during CAPTURE.
- state_o  out  3  current state encoding, for debug LEDs.

Behaviour:
- Sync and edge detection:
  - cam_vsync passes through a 2-flop synchronizer, then a registered edge detector.
  - vs_fall = frame start; vs_rise = frame end.
  - Each edge is visible to the FSM 3 clk cycles after the raw transition.
- States and encodings:
  - IDLE=0, SKIP=1, ARM=2, CAPTURE=3, HOLD=4.
- Reset:
  - state=IDLE, skip counter=0, frame_cnt=0, frame_done=0, addr_err=0, stop_pending=0, synchronizer flops=0.
  - fb_we=0 and frozen=0.
  - Reset asserted mid-frame aborts immediately; no frame_done is generated.
- IDLE:
  - Wait for cfg_done=1, then go to SKIP with skip counter cleared.
  - If c_skip_frames=0, go directly to ARM.
- SKIP:
  - Count vs_rise.
  - When the count reaches c_skip_frames, go to ARM.
- ARM:
  - On vs_fall, go to CAPTURE.
  - A vs_rise seen in ARM is ignored; this covers arming mid-frame, which must wait for the next full frame.
- CAPTURE:
  - fb_we = cap_we AND (cap_addr < c_img_pxls). This is combinational from registered state, zero latency; cap_addr is routed to the buffer unchanged.
  - If cap_we=1 and the address is out of range, the write is suppressed and addr_err is set.
  - On vs_rise:
    - frame_done pulses for exactly 1 cycle; frame_cnt increments, wrapping at 2^c_nb_frame_cnt.
    - Then go to HOLD if stop_pending=1 or mode_cont=0; otherwise go to ARM.
- HOLD:
  - fb_we=0, frozen=1.
  - snap_req clears stop_pending and goes to ARM (one frame is captured, because single-shot returns to HOLD).
  - With mode_cont=1 and stop_pending=0, go to ARM automatically.
- stop_pending:
  - Set by stop_req in any state except IDLE.
  - Cleared by snap_req in HOLD, and by reset.
  - stop_req in ARM or CAPTURE does not truncate the frame in progress.
- Simultaneous requests:
  - stop_req and snap_req in the same cycle: in HOLD, snap wins; in all other states, stop wins and snap is dropped.
- Simultaneous edges:
  - vs_rise and vs_fall cannot coincide after edge detection.
  - snap_req is accepted in HOLD only; it is dropped elsewhere.
- cfg_done deasserting in any state:
  - Go to IDLE next cycle; fb_we=0 from that cycle on.
  - No frame_done; frame_cnt and addr_err are kept.
- Outputs outside CAPTURE: fb_we=0 in every state other than CAPTURE, regardless of cap_we.
- frozen is 1 only in HOLD.

Test Plan:
- Startup skip: reset, cfg_done=1, c_skip_frames=2, mode_cont=1, 4 vsync frames of 4800 cap_we pulses each -> no fb_we during frames 1-2; frame 3 passes 4800 writes; frame_done pulses at the end of frames 3 and 4; frame_cnt=2.
- Mid-frame arm: cfg_done rises while vsync is low, after 1000 pixels have gone by -> zero writes for that partial frame; the capture starts at the next vs_fall, exactly 3 clk after the raw edge.
- Single-shot: mode_cont=0 -> one frame captured, then HOLD with frozen=1 and fb_we=0 for the following frames; snap_req in HOLD -> exactly one more frame captured, frame_cnt +1.
- Stop/snap precedence: stop_req at pixel 2000 of a continuous frame -> all 4800 writes complete, then HOLD. stop_req and snap_req in the same HOLD cycle -> ARM with stop_pending=0.
- Address range: cap_we with cap_addr=4800 and 8191 in CAPTURE -> fb_we=0, addr_err=1 and sticky; cap_addr=4799 -> fb_we=1.
- Aborts:
  - rst at pixel 3000 -> fb_we=0 next cycle, frame_cnt=0, state_o=0, no frame_done.
  - cfg_done drop mid-capture -> IDLE, frame_cnt held.
  - frame_cnt wraps from 255 to 0 after 256 captured frames.
